// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  bubble,
    input  logic [DATA_WIDTH-1:0] fetch_instr,
    input  logic [DATA_WIDTH-1:0] fetch_pc_plus4,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  valid
);

    // Bubble clears everything so decode always sees a NOP with zero PC+4.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            instr    <= DATA_WIDTH'(NOP_INSTR);
            pc_plus4 <= {DATA_WIDTH{1'b0}};
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= fetch_instr;
            pc_plus4 <= fetch_pc_plus4;
            valid    <= 1'b1;
        end else begin
            instr    <= instr;
            pc_plus4 <= pc_plus4;
            valid    <= valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch fault lock-out
// and the IF/ID register feeding decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ROM_DEPTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] BranchAdd,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rd,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  Valid,
    output logic                  Fault
);

    localparam logic [DATA_WIDTH-3:0] ROM_WORDS = (DATA_WIDTH-2)'(ROM_DEPTH);

    fetch_state_t          state_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic                  fault_r;
    logic [DATA_WIDTH-1:0] pc_plus4_s;
    logic [DATA_WIDTH-1:0] redirect_s;
    logic                  pc_bad_s;
    logic                  ifid_load_s;
    logic                  ifid_bubble_s;

    assign imem_addr  = pc_r;
    assign pc_plus4_s = pc_r + DATA_WIDTH'(PC_STEP);
    assign redirect_s = PCSrc ? BranchAdd : pc_plus4_s;
    assign pc_bad_s   = (pc_r[1:0] != 2'b00) || (pc_r[DATA_WIDTH-1:2] >= ROM_WORDS);
    assign Fault      = fault_r;

    // IF/ID control: a bad PC or a flush injects a bubble, a stall holds.
    always_comb begin
        ifid_load_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        case (state_r)
            RUN: begin
                if (pc_bad_s || Flush) begin
                    ifid_bubble_s = 1'b1;
                end else if (Stall) begin
                    ifid_load_s = 1'b0;
                end else begin
                    ifid_load_s = 1'b1;
                end
            end
            FAULT: begin
                ifid_load_s   = 1'b0;
                ifid_bubble_s = 1'b0;
            end
            default: begin
                ifid_bubble_s = 1'b1;
            end
        endcase
    end

    // PC and fault FSM; a redirect during a stall still updates the PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            state_r <= RUN;
            fault_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (pc_bad_s) begin
                        state_r <= FAULT;
                        fault_r <= 1'b1;
                    end else if (Flush || !Stall) begin
                        pc_r <= redirect_s;
                    end else if (PCSrc) begin
                        pc_r <= BranchAdd;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                FAULT: begin
                    fault_r <= 1'b1;
                end
                default: begin
                    state_r <= FAULT;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_if_id (
        .clk           (clk),
        .reset         (reset),
        .load          (ifid_load_s),
        .bubble        (ifid_bubble_s),
        .fetch_instr   (imem_rd),
        .fetch_pc_plus4(pc_plus4_s),
        .instr         (Instr),
        .pc_plus4      (PCPlus4),
        .valid         (Valid)
    );

endmodule
